// File: rtl/watch_ctrl_if.sv
// -----------------------------------------------------------------------------
// watch_ctrl_if -- control/status bundle for the stopwatch controller.
//
// Signals:
//   start_stop  pulse   toggles run/pause
//   clear       pulse   return to idle and zero the time counters
//   lap         pulse   toggles lap display hold
//   tick        out     one-cycle count enable for the seconds counter
//   cnt_clear   out     one-cycle synchronous clear for seconds/minutes
//   running     out     high while counting (RUN or LAP)
//   lap_hold    out     display latch enable (LAP)
//   state[1:0]  out     00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
//
// Modports:
//   master -- drives the pulses and observes the status (panel / bench)
//   slave  -- the controller itself
// -----------------------------------------------------------------------------
interface watch_ctrl_if;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic       tick;
  logic       cnt_clear;
  logic       running;
  logic       lap_hold;
  logic [1:0] state;

  modport master (
    output start_stop, clear, lap,
    input  tick, cnt_clear, running, lap_hold, state
  );

  modport slave (
    input  start_stop, clear, lap,
    output tick, cnt_clear, running, lap_hold, state
  );
endinterface

// File: rtl/watch_ctrl.sv
// -----------------------------------------------------------------------------
// watch_ctrl -- stopwatch control FSM with tick prescaler.
//
// Ports:
//   clk   in   sole clock, rising edge
//   rst   in   asynchronous, active-high reset
//   bus   watch_ctrl_if.slave
//           start_stop/clear/lap pulses in (edge-detected internally),
//           tick/cnt_clear/running/lap_hold/state out (all registered)
//
// Parameters:
//   TICK_DIV  clk cycles per count tick, 2..65535
//
// Build option:
//   LAP_EN  when defined, the lap input and LAP state are functional; when
//           undefined, lap is ignored, LAP is unreachable, lap_hold stays 0.
//
// Input priority on a single edge: clear > start_stop > lap; the losers are
// dropped, not queued.
// -----------------------------------------------------------------------------
module watch_ctrl #(
  parameter int TICK_DIV = 10
) (
  input  logic         clk,
  input  logic         rst,
  watch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic        ss_prev_q, clr_prev_q;
  logic        tick_q, tick_d;
  logic        cnt_clear_q, cnt_clear_d;
  logic        running_q, running_d;
  logic        lap_hold_q, lap_hold_d;

  logic        ss_rise;
  logic        clr_rise;
  logic        lap_rise;
  logic        count_en;

  assign ss_rise  = bus.start_stop & ~ss_prev_q;
  assign clr_rise = bus.clear & ~clr_prev_q;

`ifdef LAP_EN
  logic lap_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_prev_q <= 1'b0;
    end else begin
      lap_prev_q <= bus.lap;
    end
  end

  assign lap_rise = bus.lap & ~lap_prev_q;
`else
  // Lap support compiled out: the port stays, its value is discarded.
  logic unused_lap;
  assign unused_lap = bus.lap;
  assign lap_rise   = 1'b0;
`endif

  // Next state, prescaler and registered-output inputs.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    tick_d      = 1'b0;
    cnt_clear_d = 1'b0;
    running_d   = 1'b0;
    lap_hold_d  = 1'b0;
    count_en    = 1'b0;

    if (clr_rise) begin
      state_d = S_IDLE;
    end else if (ss_rise) begin
      case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        S_LAP:   state_d = S_PAUSE;
        default: state_d = S_IDLE;
      endcase
    end else if (lap_rise) begin
      case (state_q)
        S_RUN:   state_d = S_LAP;
        S_LAP:   state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end

    // A cycle counts only if the controller is counting both before and
    // after the edge. The edge that enters RUN is therefore not counted
    // (first tick lands TICK_DIV edges later), and the edge that pauses or
    // clears is not counted either, so a wrap can never put a tick into a
    // PAUSE or post-clear cycle.
    count_en = ((state_q == S_RUN) || (state_q == S_LAP)) &&
               ((state_d == S_RUN) || (state_d == S_LAP));

    if (state_d == S_IDLE) begin
      presc_d = 16'd0;
    end else if (count_en) begin
      presc_d = (presc_q == DIV_LAST) ? 16'd0 : presc_q + 16'd1;
    end

    tick_d      = count_en && (presc_q == DIV_LAST);
    // clear always requests a counter wipe, whatever state it arrives in.
    cnt_clear_d = clr_rise;
    running_d   = (state_d == S_RUN) || (state_d == S_LAP);
    lap_hold_d  = (state_d == S_LAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      presc_q     <= 16'd0;
      ss_prev_q   <= 1'b0;
      clr_prev_q  <= 1'b0;
      tick_q      <= 1'b0;
      cnt_clear_q <= 1'b0;
      running_q   <= 1'b0;
      lap_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      ss_prev_q   <= bus.start_stop;
      clr_prev_q  <= bus.clear;
      tick_q      <= tick_d;
      cnt_clear_q <= cnt_clear_d;
      running_q   <= running_d;
      lap_hold_q  <= lap_hold_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.tick      = tick_q;
  assign bus.cnt_clear = cnt_clear_q;
  assign bus.running   = running_q;
  assign bus.lap_hold  = lap_hold_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_watch_ctrl -- self-checking bench for watch_ctrl (TICK_DIV = 10).
// Behaviour is tracked by a reference model that counts enabled cycles since
// the last return to idle and expects a tick whenever that total is a multiple
// of TICK_DIV. Works with or without LAP_EN defined.
// -----------------------------------------------------------------------------
module tb_watch_ctrl;
  localparam int DIV = 10;

  logic clk;
  logic rst;
  watch_ctrl_if bus ();

  watch_ctrl #(.TICK_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_state;
  int m_enabled;
  bit m_tick, m_cclr;
  bit m_ss_prev, m_clr_prev, m_lap_prev;
  int ss_next[4]  = '{1, 2, 1, 2};
  int lap_next[4] = '{0, 3, 2, 1};

  function automatic bit counting(int s);
    return (s == 1) || (s == 3);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_enabled = 0; m_tick = 0; m_cclr = 0;
    m_ss_prev = 0; m_clr_prev = 0; m_lap_prev = 0;
  endtask

  task automatic model_step(bit ss, bit clr, bit lp);
    bit ss_r, clr_r, lap_r, en;
    int nxt;
    ss_r  = ss & ~m_ss_prev;
    clr_r = clr & ~m_clr_prev;
    lap_r = lp & ~m_lap_prev & LAP_ON;
    nxt = m_state;
    if (clr_r)      nxt = 0;
    else if (ss_r)  nxt = ss_next[m_state];
    else if (lap_r) nxt = lap_next[m_state];
    en = counting(m_state) && counting(nxt);
    m_tick = 0;
    if (en) begin
      m_enabled++;
      m_tick = (m_enabled % DIV) == 0;
    end
    if (nxt == 0) m_enabled = 0;
    m_cclr = clr_r;
    m_state = nxt;
    m_ss_prev = ss; m_clr_prev = clr; m_lap_prev = lp;
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".state"},     int'(bus.state),     m_state);
    chk({tag, ".tick"},      int'(bus.tick),      int'(m_tick));
    chk({tag, ".cnt_clear"}, int'(bus.cnt_clear), int'(m_cclr));
    chk({tag, ".running"},   int'(bus.running),   int'(counting(m_state)));
    chk({tag, ".lap_hold"},  int'(bus.lap_hold),  int'(m_state == 3));
  endtask

  // One clock: drive, edge, update model, sample 1 ns later.
  task automatic cycle(bit ss, bit clr, bit lp, string tag);
    bus.start_stop = ss; bus.clear = clr; bus.lap = lp;
    @(posedge clk);
    model_step(ss, clr, lp);
    #1;
    check_outputs(tag);
  endtask

  typedef struct {
    bit    ss, clr, lp;
    int    exp_state;
    bit    exp_cclr;
    string name;
  } vec_t;

  vec_t vecs[19];

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, "idle_quiet"};
    vecs[1]  = '{0, 0, 1, 0, 0, "idle_lap_ignored"};
    vecs[2]  = '{0, 1, 0, 0, 1, "idle_clear"};
    vecs[3]  = '{1, 0, 0, 1, 0, "start"};
    vecs[4]  = '{1, 0, 0, 1, 0, "ss_held"};
    vecs[5]  = '{0, 0, 0, 1, 0, "run"};
    vecs[6]  = '{1, 0, 0, 2, 0, "pause"};
    vecs[7]  = '{0, 0, 0, 2, 0, "paused"};
    vecs[8]  = '{0, 1, 0, 0, 1, "clear_pause"};
    vecs[9]  = '{1, 0, 0, 1, 0, "start2"};
    vecs[10] = '{0, 0, 0, 1, 0, "run2"};
    vecs[11] = '{1, 1, 0, 0, 1, "clear_beats_ss"};
    vecs[12] = '{0, 0, 0, 0, 0, "cc_one_cycle"};
    vecs[13] = '{1, 0, 0, 1, 0, "start3"};
    vecs[14] = '{0, 0, 0, 1, 0, "run3"};
    vecs[15] = '{1, 0, 1, 2, 0, "ss_beats_lap"};
    vecs[16] = '{0, 0, 0, 2, 0, "paused2"};
    vecs[17] = '{1, 0, 0, 1, 0, "resume"};
    vecs[18] = '{0, 1, 1, 0, 1, "clear_beats_lap"};

    bus.start_stop = 0; bus.clear = 0; bus.lap = 0;
    rst = 1'b1;
    model_reset();
    #50;
    check_outputs("reset");
    #50;
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 19; i++) begin
      cycle(vecs[i].ss, vecs[i].clr, vecs[i].lp, vecs[i].name);
      chk({"tbl.", vecs[i].name, ".state"}, int'(bus.state), vecs[i].exp_state);
      chk({"tbl.", vecs[i].name, ".cclr"}, int'(bus.cnt_clear), int'(vecs[i].exp_cclr));
      chk({"tbl.", vecs[i].name, ".tick"}, int'(bus.tick), 0);
    end
    cycle(0, 0, 0, "settle");

    // First tick 10 cycles after RUN edge, then every 10
    cycle(1, 0, 0, "tick_start");
    chk("tick_start.state", int'(bus.state), 1);
    for (int i = 1; i <= 25; i++) begin
      cycle(0, 0, 0, "tick_run");
      chk("tick_period", int'(bus.tick), int'((i % 10) == 0));
    end

    // Pause 4 enabled cycles into a period, resume, tick 6 cycles later
    cycle(0, 1, 0, "p_clear");
    cycle(1, 0, 0, "p_start");
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, "p_run4");
    cycle(1, 0, 0, "p_pause");
    chk("p_pause.state", int'(bus.state), 2);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, "p_wait");
      chk("p_no_tick_paused", int'(bus.tick), 0);
    end
    cycle(1, 0, 0, "p_resume");
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, "p_after");
      chk("p_tick_after_resume", int'(bus.tick), int'(i == 6));
    end

    // clear in RUN: cnt_clear one cycle, no tick for 10 cycles
    cycle(0, 1, 0, "c_clear");
    chk("c_clear.state", int'(bus.state), 0);
    chk("c_clear.cclr", int'(bus.cnt_clear), 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, "c_idle");
      chk("c_no_tick", int'(bus.tick), 0);
      chk("c_cclr_low", int'(bus.cnt_clear), 0);
    end
    // restart: prescaler must have been zeroed
    cycle(1, 0, 0, "c_restart");
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 0, "c_rerun");
      chk("c_first_tick", int'(bus.tick), int'(i == 10));
    end

    // lap in RUN
    cycle(0, 0, 1, "l_lap");
    chk("l_lap.state", int'(bus.state), LAP_ON ? 3 : 1);
    chk("l_lap.hold", int'(bus.lap_hold), int'(LAP_ON));
    for (int i = 1; i <= 10; i++) begin
      cycle(0, 0, 0, "l_count");
      chk("l_tick_in_lap", int'(bus.tick), int'(i == 9));
    end
    cycle(1, 0, 0, "l_pause");
    chk("l_pause.state", int'(bus.state), 2);
    chk("l_pause.hold", int'(bus.lap_hold), 0);

    // Asynchronous reset mid-RUN
    cycle(1, 0, 0, "r_resume");
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, "r_run");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("r_async");
    #2;
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 0, "r_after");
      chk("r_no_tick", int'(bus.tick), 0);
    end
    cycle(1, 0, 0, "r_start");
    chk("r_start.state", int'(bus.state), 1);

    // Randomized stimulus against the model
    begin
      bit ss, clr, lp;
      ss = 0; clr = 0; lp = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 9) == 0)  ss  = ~ss;
        if ($urandom_range(0, 59) == 0) clr = ~clr;
        if ($urandom_range(0, 11) == 0) lp  = ~lp;
        cycle(ss, clr, lp, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
